out_col_deskew: RTL and testbench

Output deskew and buffering stage for the systolic array's bottom-row results; successor to the single-lane output shift register. Column j of an N-column array delivers its result j cycles after column 0. This block delays each active column so a full row emerges as one aligned word, and buffers aligned words in a small FIFO with valid/ready backpressure toward the write-back path. The number of active columns is run-time loadable.

---
 rtl/out_deskew_pkg.sv | 25 ++
 rtl/out_deskew_fifo.sv | 65 ++++++
 rtl/out_col_deskew.sv | 140 ++++++++++++++
 tb/tb_out_col_deskew.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/out_deskew_pkg.sv
// Shared widths and helpers for the output column deskew stage.
package out_deskew_pkg;

    localparam int I_WIDTH_DEF    = 8;
    localparam int F_WIDTH_DEF    = 8;
    localparam int N_DEF          = 3;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DATA_W_DEF     = I_WIDTH_DEF + F_WIDTH_DEF;

    function automatic int calc_data_w(input int i_w, input int f_w);
        return i_w + f_w;
    endfunction

    // LSB position of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_PTR_W_DEF = fifo_ptr_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/out_deskew_fifo.sv
// Aligned-word buffer: synchronous FIFO, head visible combinationally, zero while empty.
// Latency: push visible on out the cycle after the write edge. Backpressure: push while full without pop is dropped and flagged.
// Pop honoured only when non-empty; push+pop when full is legal.
module out_deskew_fifo
    import out_deskew_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign drop_o  = push_i & full_o & ~do_pop;
    assign do_push = push_i & ~drop_o;

    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/out_col_deskew.sv
// Realigns staggered systolic column results into one row word and buffers it; optional ReLU via OUT_RELU_EN.
// Latency: row launched in cycle k is on out_data_o from cycle k+ncol. One row per cycle.
// Backpressure: out_valid_o/out_ready_i; a full FIFO drops new rows and sets sticky overflow_o.
module out_col_deskew
    import out_deskew_pkg::*;
#(
    parameter int I_WIDTH    = 8,
    parameter int F_WIDTH    = 8,
    parameter int N          = 3,
    parameter int COL_WIDTH  = $clog2(N+1),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [N*calc_data_w(I_WIDTH, F_WIDTH)-1:0]   in_data_i,
    input  logic                                         in_valid_i,
    input  logic [COL_WIDTH-1:0]                         number_of_columns_i,
    input  logic                                         number_of_columns_ld_i,
    output logic [COL_WIDTH-1:0]                         number_of_columns_o,
    output logic [N*calc_data_w(I_WIDTH, F_WIDTH)-1:0]   out_data_o,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    output logic                                         overflow_o,
    output logic                                         busy_o
);

    localparam int DATA_W = calc_data_w(I_WIDTH, F_WIDTH);
    localparam int VLD_W  = (N > 1) ? N - 1 : 1;
    localparam logic [COL_WIDTH-1:0] N_COL = COL_WIDTH'(N);

    logic [COL_WIDTH-1:0] ncol_q, ncol_d;
    logic                 ovf_q, ovf_d;
    logic [VLD_W-1:0]     vld_q, vld_d;
    logic [DATA_W-1:0]    lane_in [N];
    logic [DATA_W-1:0]    lane_al [N];
    logic [N*DATA_W-1:0]  al_word;
    logic                 al_vld;
    logic                 ld_ok;
    logic                 fifo_full, fifo_empty, fifo_drop;

    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_lane
            assign lane_in[j] = in_data_i[lane_lsb(j, DATA_W) +: DATA_W];

            if (N - 1 - j > 0) begin : g_chain
                localparam int L = N - 1 - j;
                logic [DATA_W-1:0] chain_q [L];
                logic [DATA_W-1:0] tap;
                int                dly;

                always_ff @(posedge clk_i) begin
                    if (!rst_n_i) begin
                        for (int s = 0; s < L; s++) chain_q[s] <= '0;
                    end else begin
                        chain_q[0] <= lane_in[j];
                        for (int s = 1; s < L; s++) chain_q[s] <= chain_q[s-1];
                    end
                end

                // Lane j of an ncol-wide row needs ncol-1-j cycles of delay to line up with lane 0.
                always_comb begin
                    tap = '0;
                    dly = int'(ncol_q) - 1 - j;
                    if (int'(ncol_q) > j) begin
                        if (dly == 0) tap = lane_in[j];
                        for (int s = 0; s < L; s++) begin
                            if (dly == s + 1) tap = chain_q[s];
                        end
                    end
                end

                assign lane_al[j] = tap;
            end else begin : g_nochain
                assign lane_al[j] = (int'(ncol_q) > j) ? lane_in[j] : '0;
            end

`ifdef OUT_RELU_EN
            assign al_word[lane_lsb(j, DATA_W) +: DATA_W] = lane_al[j][DATA_W-1] ? '0 : lane_al[j];
`else
            assign al_word[lane_lsb(j, DATA_W) +: DATA_W] = lane_al[j];
`endif
        end
    endgenerate

    always_comb begin
        vld_d    = '0;
        vld_d[0] = (N > 1) ? in_valid_i : 1'b0;
        for (int s = 1; s < VLD_W; s++) vld_d[s] = vld_q[s-1];
    end

    always_comb begin
        al_vld = 1'b0;
        if (ncol_q == COL_WIDTH'(1)) al_vld = in_valid_i;
        for (int s = 0; s < VLD_W; s++) begin
            if ((N > 1) && (int'(ncol_q) == s + 2)) al_vld = vld_q[s];
        end
    end

    assign busy_o = (|vld_q) | out_valid_o | in_valid_i;
    assign ld_ok  = number_of_columns_ld_i & ~busy_o &
                    (number_of_columns_i != '0) & (number_of_columns_i <= N_COL);

    always_comb begin
        ncol_d = ld_ok ? number_of_columns_i : ncol_q;
        ovf_d  = ld_ok ? 1'b0 : (ovf_q | (fifo_drop & fifo_full));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ncol_q <= N_COL;
            ovf_q  <= 1'b0;
            vld_q  <= '0;
        end else begin
            ncol_q <= ncol_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    out_deskew_fifo #(
        .WIDTH (N*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (al_vld),
        .push_dat_i (al_word),
        .pop_i      (out_ready_i),
        .pop_dat_o  (out_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop)
    );

    assign out_valid_o         = ~fifo_empty;
    assign number_of_columns_o = ncol_q;
    assign overflow_o          = ovf_q;

endmodule

// File: tb/tb_out_col_deskew.sv
// Randomized bench for out_col_deskew against a row/queue reference model.
module tb_out_col_deskew;

    localparam int N     = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*DW-1:0] in_data;
    logic          in_valid;
    logic [1:0]    ncol_in;
    logic          ncol_ld;
    logic [1:0]    ncol_out;
    logic [N*DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    out_col_deskew #(
        .I_WIDTH(8), .F_WIDTH(8), .N(N), .COL_WIDTH(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i                  (clk),
        .rst_n_i                (rst_n),
        .in_data_i              (in_data),
        .in_valid_i             (in_valid),
        .number_of_columns_i    (ncol_in),
        .number_of_columns_ld_i (ncol_ld),
        .number_of_columns_o    (ncol_out),
        .out_data_o             (out_data),
        .out_valid_o            (out_valid),
        .out_ready_i            (out_ready),
        .overflow_o             (overflow),
        .busy_o                 (busy)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: every input cycle is recorded; a row launched at cycle k
    // collects lane j from cycle k+j and enters the queue at the end of cycle k+ncol-1.
    logic [N*DW-1:0] hist_d [MAXC];
    bit              hist_v [MAXC];
    logic [N*DW-1:0] q [$];
    int              cyc_n   = 0;
    int              rst_cyc = -1;
    int              ncol_m  = N;
    bit              ovf_m   = 0;

    function automatic bit vh(input int i);
        if (i < 0 || i <= rst_cyc) return 1'b0;
        return hist_v[i];
    endfunction

    function automatic logic [DW-1:0] hv(input int i, input int lane);
        logic [N*DW-1:0] w;
        if (i < 0 || i <= rst_cyc) return '0;
        w = hist_d[i];
        return w[lane*DW +: DW];
    endfunction

    function automatic logic [N*DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[N*DW-1:0];
    endfunction

    task automatic cyc();
        int              base;
        bit              pop, push, bz;
        logic [N*DW-1:0] w;
        logic [DW-1:0]   v;
        #1;
        hist_d[cyc_n] = in_data;
        hist_v[cyc_n] = in_valid;
        bz = in_valid || (q.size() > 0);
        for (int d = 1; d < N; d++) if (vh(cyc_n - d)) bz = 1'b1;
        chk_eq("busy", {63'd0, busy}, {63'd0, bz});
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            ovf_m   = 1'b0;
            ncol_m  = N;
            rst_cyc = cyc_n;
        end else begin
            pop  = (q.size() > 0) && out_ready;
            base = cyc_n - (ncol_m - 1);
            push = vh(base);
            w    = '0;
            for (int j = 0; j < ncol_m; j++) begin
                v = hv(base + j, j);
`ifdef OUT_RELU_EN
                if (v[DW-1]) v = '0;
`endif
                w[j*DW +: DW] = v;
            end
            if (push && q.size() == DEPTH && !pop) begin
                ovf_m = 1'b1;
            end else begin
                if (pop) q.delete(0);
                if (push) q.push_back(w);
            end
            if (ncol_ld && !bz && ncol_in >= 1 && int'(ncol_in) <= N) begin
                ncol_m = int'(ncol_in);
                ovf_m  = 1'b0;
            end
        end
        cyc_n++;
        #1;
        chk_eq("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
        chk_eq("out_data", {16'd0, out_data}, (q.size() > 0) ? {16'd0, q[0]} : 64'd0);
        chk_eq("overflow", {63'd0, overflow}, {63'd0, ovf_m});
        chk_eq("ncol", {62'd0, ncol_out}, 64'(ncol_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = rnd_word();
            ncol_ld  = 1'b0;
            cyc();
        end
    endtask

    logic [N*DW-1:0] w0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        ncol_in = 2'd0; ncol_ld = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        chk_eq("rst_ncol", {62'd0, ncol_out}, 64'd3);
        chk_eq("rst_data", {16'd0, out_data}, 64'd0);
        idle(3);

        // Staggered row, three columns
        w0 = rnd_word(); w0[15:0] = 16'h0100; in_data = w0; in_valid = 1'b1; cyc();
        w0 = rnd_word(); w0[31:16] = 16'h0200; in_data = w0; in_valid = 1'b0; cyc();
        w0 = rnd_word(); w0[47:32] = 16'h0300; in_data = w0; cyc();
        chk_eq("row3_vld", {63'd0, out_valid}, 64'd1);
        chk_eq("row3_dat", {16'd0, out_data}, 64'h0000_0300_0200_0100);
        idle(1);
        chk_eq("row3_one", {63'd0, out_valid}, 64'd0);
        idle(3);

        // Two active columns
        ncol_in = 2'd2; ncol_ld = 1'b1; cyc(); ncol_ld = 1'b0;
        chk_eq("ld2", {62'd0, ncol_out}, 64'd2);
        w0 = rnd_word(); w0[15:0] = 16'h0005; in_data = w0; in_valid = 1'b1; cyc();
        w0 = rnd_word(); w0[31:16] = 16'h0007; in_data = w0; in_valid = 1'b0; cyc();
        chk_eq("row2_dat", {16'd0, out_data}, 64'h0000_0000_0007_0005);
        idle(3);
        ncol_in = 2'd3; ncol_ld = 1'b1; cyc(); ncol_ld = 1'b0;
        idle(2);

        // Rejected loads: while busy, and with zero
        in_valid = 1'b1; in_data = rnd_word(); ncol_in = 2'd1; ncol_ld = 1'b1; cyc();
        in_valid = 1'b0; cyc(); ncol_ld = 1'b0;
        chk_eq("ld_busy", {62'd0, ncol_out}, 64'd3);
        idle(4);
        ncol_in = 2'd0; ncol_ld = 1'b1; cyc(); ncol_ld = 1'b0;
        chk_eq("ld_zero", {62'd0, ncol_out}, 64'd3);

        // Overflow: five rows into a four-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = rnd_word(); cyc();
        end
        idle(4);
        chk_eq("ovf_set", {63'd0, overflow}, 64'd1);
        out_ready = 1'b1;
        idle(6);
        chk_eq("ovf_sticky", {63'd0, overflow}, 64'd1);
        ncol_in = 2'd3; ncol_ld = 1'b1; cyc(); ncol_ld = 1'b0;
        chk_eq("ovf_clr", {63'd0, overflow}, 64'd0);

        // Negative values
        in_data = {3{16'hFF00}}; in_valid = 1'b1; cyc();
        in_valid = 1'b0; cyc(); cyc();
`ifdef OUT_RELU_EN
        chk_eq("relu", {16'd0, out_data}, 64'd0);
`else
        chk_eq("relu", {16'd0, out_data}, 64'h0000_FF00_FF00_FF00);
`endif
        idle(3);

        // Random traffic with loads, backpressure and occasional reset
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 50);
            in_data   = rnd_word();
            out_ready = ($urandom_range(0, 99) < 65);
            ncol_ld   = ($urandom_range(0, 99) < 8);
            ncol_in   = 2'($urandom_range(0, 3));
            rst_n     = ($urandom_range(0, 199) != 0);
            cyc();
            rst_n = 1'b1;
        end

        // Reset mid-stream
        out_ready = 1'b0; ncol_ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rnd_word(); cyc();
        end
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        chk_eq("mid_rst_vld", {63'd0, out_valid}, 64'd0);
        chk_eq("mid_rst_ncol", {62'd0, ncol_out}, 64'd3);
        chk_eq("mid_rst_ovf", {63'd0, overflow}, 64'd0);
        #1;
        chk_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        idle(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
